maxpool_scheduler: RTL

//  2x2/stride-2 max-pool engine directly downstream of the ReLU pass on picture memory.

---
 rtl/maxpool_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/maxpool_scheduler.sv
// ============================================================================
// maxpool_scheduler : 2x2/stride-2 signed max-pool engine, one write per 6 cycles.
// Optional build macro MAXPOOL_RELU_FUSE_EN clamps negative pooled values to 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module maxpool_scheduler #(
  parameter int ADDR_BIT = 10,
  parameter int DATA_BIT = 16,
  parameter int IMG_W0   = 24,
  parameter int IMG_W1   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  output logic [ADDR_BIT-1:0] src_addr,
  input  logic [DATA_BIT-1:0] src_rdata,
  output logic [ADDR_BIT-1:0] dst_addr,
  output logic                dst_we,
  output logic [DATA_BIT-1:0] dst_wdata,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [ADDR_BIT-1:0] C_W0  = ADDR_BIT'(IMG_W0);
  localparam logic [ADDR_BIT-1:0] C_W1  = ADDR_BIT'(IMG_W1);
  localparam logic [ADDR_BIT-1:0] C_ONE = ADDR_BIT'(1);
  localparam logic [ADDR_BIT-1:0] C_TWO = ADDR_BIT'(2);

  logic [1:0]                 state;
  logic [1:0]                 k;
  logic [ADDR_BIT-1:0]        width;
  logic [ADDR_BIT-1:0]        base;
  logic [ADDR_BIT-1:0]        row;
  logic [ADDR_BIT-1:0]        col;
  logic [ADDR_BIT-1:0]        out_cnt;
  logic [ADDR_BIT-1:0]        last_addr;
  logic signed [DATA_BIT-1:0] max_r;
  logic signed [DATA_BIT-1:0] last_data;

  logic [ADDR_BIT-1:0]        half_m1;
  logic                       last_win;
  logic signed [DATA_BIT-1:0] rdata_s;
  logic signed [DATA_BIT-1:0] pooled;

  assign half_m1  = (width >> 1) - C_ONE;
  assign last_win = (row == half_m1) && (col == half_m1);
  assign rdata_s  = src_rdata;

`ifdef MAXPOOL_RELU_FUSE_EN
  assign pooled = max_r[DATA_BIT-1] ? '0 : max_r;
`else
  assign pooled = max_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= 2'd0;
      width     <= '0;
      base      <= '0;
      row       <= '0;
      col       <= '0;
      out_cnt   <= '0;
      max_r     <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            k       <= 2'd0;
            width   <= mode ? C_W1 : C_W0;
            base    <= '0;
            row     <= '0;
            col     <= '0;
            out_cnt <= '0;
          end
        end
        S_FETCH: begin
          k <= k + 2'd1;
          // Read data lags the address by one cycle: k=1 sees the first pixel.
          if (k == 2'd1) begin
            max_r <= rdata_s;
          end else if ((k != 2'd0) && (rdata_s > max_r)) begin
            max_r <= rdata_s;
          end
          if (k == 2'd3) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rdata_s > max_r) begin
            max_r <= rdata_s;
          end
          state <= S_WRITE;
        end
        S_WRITE: begin
          last_addr <= out_cnt;
          last_data <= pooled;
          if (last_win) begin
            state <= S_IDLE;
          end else begin
            state   <= S_FETCH;
            k       <= 2'd0;
            out_cnt <= out_cnt + C_ONE;
            // Stepping past the last column jumps over the odd row of the pair.
            if (col == half_m1) begin
              col  <= '0;
              row  <= row + C_ONE;
              base <= base + width + C_TWO;
            end else begin
              col  <= col + C_ONE;
              base <= base + C_TWO;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    src_addr = '0;
    if (state == S_FETCH) begin
      src_addr = base + (k[1] ? width : '0) + {{(ADDR_BIT-1){1'b0}}, k[0]};
    end
  end

  assign dst_we    = (state == S_WRITE);
  assign done      = dst_we && last_win;
  assign busy      = (state != S_IDLE);
  assign dst_addr  = dst_we ? out_cnt : last_addr;
  assign dst_wdata = dst_we ? pooled : last_data;

endmodule

`default_nettype wire
